// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: decodes button presses, launches the ALU,
// waits for completion or timeout, writes the result to memory and shows it.
module calc_op_sequencer #(
  parameter int          TIMEOUT  = 32,
  parameter logic [15:0] ERR_CODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        add,
  input  logic        subtract,
  input  logic        multiply,
  input  logic        divide,
  input  logic        clear,
  input  logic [15:0] sw,
  output logic        alu_start,
  output logic [1:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [1:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;
  localparam int         CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_SHOW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             pend_vld;
  logic [1:0]       pend_op;
  logic             req_vld;
  logic [1:0]       req_op;
  logic             take_vld;
  logic [1:0]       take_op;

  // Fixed-priority decode of the op buttons; clear is handled separately.
  always_comb begin
    req_vld = 1'b1;
    req_op  = OP_ADD;
    if (add)           req_op = OP_ADD;
    else if (subtract) req_op = OP_SUB;
    else if (multiply) req_op = OP_MUL;
    else if (divide)   req_op = OP_DIV;
    else               req_vld = 1'b0;
  end

  // A fresh press in IDLE/SHOW supersedes whatever is still pending.
  always_comb begin
    take_vld = req_vld | pend_vld;
    take_op  = req_vld ? req_op : pend_op;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      count      <= '0;
      pend_vld   <= 1'b0;
      pend_op    <= 2'd0;
      alu_start  <= 1'b0;
      alu_opcode <= 2'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b1;
      mem_addr   <= 2'd0;
      mem_wdata  <= 16'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (busy && req_vld) begin
        pend_vld <= 1'b1;
        pend_op  <= req_op;
      end

      if (clear) begin
        state     <= S_WRITE;
        busy      <= 1'b1;
        pend_vld  <= 1'b0;
        mem_we    <= 1'b1;
        mem_oe    <= 1'b0;
        mem_addr  <= 2'd0;
        mem_wdata <= 16'd0;
        err       <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_SHOW: begin
            if (take_vld) begin
              pend_vld   <= 1'b0;
              alu_opcode <= take_op;
              alu_a      <= sw[15:8];
              alu_b      <= sw[7:0];
              busy       <= 1'b1;
              mem_oe     <= 1'b0;
              if (take_op == OP_DIV && sw[7:0] == 8'd0) begin
                // Divide by zero never reaches the ALU.
                state     <= S_WRITE;
                mem_we    <= 1'b1;
                mem_addr  <= take_op;
                mem_wdata <= ERR_CODE;
                err       <= 1'b1;
              end else begin
                state     <= S_LAUNCH;
                alu_start <= 1'b1;
              end
            end
          end

          S_LAUNCH: begin
            state <= S_WAIT;
            count <= CNT_W'(1);
          end

          S_WAIT: begin
            // alu_done is checked first so a completion on the last cycle wins.
            if (alu_done) begin
              state     <= S_WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= alu_opcode;
              mem_wdata <= alu_result;
            end else if (count == CNT_W'(TIMEOUT)) begin
              state     <= S_WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= alu_opcode;
              mem_wdata <= ERR_CODE;
              err       <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end

          S_WRITE: begin
            state  <= S_SHOW;
            busy   <= 1'b0;
            mem_we <= 1'b0;
            mem_oe <= 1'b1;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: vector table plus corner-case sequences.
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        add, subtract, multiply, divide, clear;
  logic [15:0] sw;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        mem_we, mem_oe;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy, err;

  int tests  = 0;
  int failed = 0;

  calc_op_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .add(add), .subtract(subtract), .multiply(multiply), .divide(divide), .clear(clear),
    .sw(sw),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  btn;    // {clear, add, subtract, multiply, divide}
    logic [15:0] sw;
    int          delay;  // cycles after alu_start to pulse alu_done; 0 = never
    logic [15:0] res;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        err;
    int          lat;    // cycles from alu_start to mem_we
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    chk({tag, "_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_oe"}, 32'(mem_oe), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic press(input logic [4:0] btn);
    {clear, add, subtract, multiply, divide} = btn;
    tick();
    {clear, add, subtract, multiply, divide} = 5'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    int n;
    t = $sformatf("v%0d", idx);
    sw = v.sw;
    press(v.btn);
    chk({t, "_start"}, 32'(alu_start), 32'(v.start));
    if (v.start) begin
      chk({t, "_opcode"}, 32'(alu_opcode), 32'(v.op));
      chk({t, "_a"}, 32'(alu_a), 32'(v.sw[15:8]));
      chk({t, "_b"}, 32'(alu_b), 32'(v.sw[7:0]));
      n = 0;
      while (!mem_we && n < 100) begin
        if (v.delay != 0 && n == v.delay - 1) begin
          alu_done   = 1'b1;
          alu_result = v.res;
        end
        tick();
        alu_done = 1'b0;
        n++;
        if (n == 1) chk({t, "_start_pulse"}, 32'(alu_start), 32'd0);
      end
      chk({t, "_lat"}, 32'(n), 32'(v.lat));
    end
    chk({t, "_we"}, 32'(mem_we), 32'd1);
    chk({t, "_oe_wr"}, 32'(mem_oe), 32'd0);
    chk({t, "_addr"}, 32'(mem_addr), 32'(v.addr));
    chk({t, "_wdata"}, 32'(mem_wdata), 32'(v.wdata));
    chk({t, "_err"}, 32'(err), 32'(v.err));
    tick();
    chk({t, "_show_oe"}, 32'(mem_oe), 32'd1);
    chk({t, "_show_we"}, 32'(mem_we), 32'd0);
    chk({t, "_show_busy"}, 32'(busy), 32'd0);
    chk({t, "_show_addr"}, 32'(mem_addr), 32'(v.addr));
  endtask

  initial begin
    int n;
    int starts;
    int writes;

    vecs[0]  = '{5'b01000, 16'h0C05,  3, 16'h0011, 1'b1, 2'd3, 2'd3, 16'h0011, 1'b0,  3};
    vecs[1]  = '{5'b00100, 16'h2010,  2, 16'h0010, 1'b1, 2'd2, 2'd2, 16'h0010, 1'b0,  2};
    vecs[2]  = '{5'b00010, 16'h0304,  5, 16'h000C, 1'b1, 2'd0, 2'd0, 16'h000C, 1'b0,  5};
    vecs[3]  = '{5'b00001, 16'h0A00,  0, 16'h0000, 1'b0, 2'd1, 2'd1, 16'hFFFF, 1'b1,  0};
    vecs[4]  = '{5'b00001, 16'h0A02,  2, 16'h0005, 1'b1, 2'd1, 2'd1, 16'h0005, 1'b1,  2};
    vecs[5]  = '{5'b10000, 16'h0000,  0, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 1'b0,  0};
    vecs[6]  = '{5'b00010, 16'h0102,  0, 16'h0000, 1'b1, 2'd0, 2'd0, 16'hFFFF, 1'b1, 33};
    vecs[7]  = '{5'b10000, 16'h0000,  0, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 1'b0,  0};
    vecs[8]  = '{5'b01010, 16'h0506,  2, 16'h000B, 1'b1, 2'd3, 2'd3, 16'h000B, 1'b0,  2};
    vecs[9]  = '{5'b00101, 16'h0900,  4, 16'h0009, 1'b1, 2'd2, 2'd2, 16'h0009, 1'b0,  4};
    vecs[10] = '{5'b11000, 16'h0C05,  0, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 1'b0,  0};
    vecs[11] = '{5'b00010, 16'h0203, 33, 16'h0006, 1'b1, 2'd0, 2'd0, 16'h0006, 1'b0, 33};

    reset_n = 1'b0;
    {clear, add, subtract, multiply, divide} = 5'b0;
    sw = 16'h0;
    alu_done = 1'b0;
    alu_result = 16'h0;
    tick();
    tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Pending slot: two presses while busy, last one wins, launched after SHOW.
    sw = 16'h0C05;
    press(5'b01000);
    chk("pend_first_start", 32'(alu_start), 32'd1);
    tick();
    press(5'b01000);
    press(5'b00100);
    sw = 16'h3321;
    alu_done = 1'b1;
    alu_result = 16'h0011;
    tick();
    alu_done = 1'b0;
    chk("pend_first_we", 32'(mem_we), 32'd1);
    chk("pend_first_addr", 32'(mem_addr), 32'd3);
    chk("pend_first_wdata", 32'(mem_wdata), 32'h0011);
    tick();
    chk("pend_show_busy", 32'(busy), 32'd0);
    n = 0;
    while (!alu_start && n < 5) begin
      tick();
      n++;
    end
    chk("pend_launch", 32'(alu_start), 32'd1);
    chk("pend_opcode", 32'(alu_opcode), 32'd2);
    chk("pend_a", 32'(alu_a), 32'h33);
    chk("pend_b", 32'(alu_b), 32'h21);
    tick();
    alu_done = 1'b1;
    alu_result = 16'h0012;
    tick();
    alu_done = 1'b0;
    chk("pend_second_we", 32'(mem_we), 32'd1);
    chk("pend_second_addr", 32'(mem_addr), 32'd2);
    chk("pend_second_wdata", 32'(mem_wdata), 32'h0012);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (alu_start) starts++;
    end
    chk("pend_no_extra_start", 32'(starts), 32'd0);
    chk("pend_idle_busy", 32'(busy), 32'd0);

    // Clear during WAIT clears err and ignores the late alu_done.
    sw = 16'h0A00;
    press(5'b00001);
    tick();
    chk("clrw_err_set", 32'(err), 32'd1);
    sw = 16'h0203;
    press(5'b00010);
    tick();
    press(5'b10000);
    chk("clrw_we", 32'(mem_we), 32'd1);
    chk("clrw_addr", 32'(mem_addr), 32'd0);
    chk("clrw_wdata", 32'(mem_wdata), 32'h0000);
    chk("clrw_err", 32'(err), 32'd0);
    chk("clrw_start", 32'(alu_start), 32'd0);
    alu_done = 1'b1;
    alu_result = 16'h1234;
    tick();
    alu_done = 1'b0;
    starts = 0;
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      if (alu_start) starts++;
      if (mem_we) writes++;
      tick();
    end
    chk("clrw_late_we", 32'(writes), 32'd0);
    chk("clrw_late_start", 32'(starts), 32'd0);
    chk("clrw_late_wdata", 32'(mem_wdata), 32'h0000);

    // Reset overrides an in-flight WAIT with a pending op.
    sw = 16'h0C05;
    press(5'b01000);
    tick();
    press(5'b00100);
    reset_n = 1'b0;
    tick();
    check_reset_vals("rstw");
    reset_n = 1'b1;
    alu_done = 1'b1;
    alu_result = 16'h5555;
    tick();
    alu_done = 1'b0;
    starts = 0;
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      if (alu_start) starts++;
      if (mem_we) writes++;
      tick();
    end
    chk("rstw_no_start", 32'(starts), 32'd0);
    chk("rstw_no_write", 32'(writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
